// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction fetch unit:
//                reset PC default, NOP encoding, response FIFO depth, the
//                FIFO entry layout and the fetch FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam logic [31:0] c_reset_pc   = 32'h0000_0000;
  localparam logic [31:0] c_nop_instr  = 32'h0000_0013;
  localparam int unsigned c_fifo_depth = 3;

  // One buffered fetch response: byte address plus instruction word.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Fetch FSM: BOOT while held in reset, RUN once released.
  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_t;

  // Circular pointer increment for the non-power-of-two FIFO depth.
  function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
    return (ptr == 2'(c_fifo_depth - 1)) ? 2'd0 : ptr + 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Three-entry response buffer of {pc, instr}. Head is visible
//                combinationally; flush empties it in one edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_data,
  output fetch_entry_t o_head,
  output logic [1:0]   o_count
);

  localparam logic [1:0] c_full = 2'(c_fifo_depth);

  fetch_entry_t r_mem [c_fifo_depth];
  logic [1:0]   r_rd_ptr;
  logic [1:0]   r_wr_ptr;
  logic [1:0]   r_count;

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Entry storage: written on push, no reset needed since count gates use.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy tracking; flush and reset both empty the buffer.
  always_ff @(posedge clk) begin
    if (!rstn || i_flush) begin
      r_rd_ptr <= 2'd0;
      r_wr_ptr <= 2'd0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (i_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // The issue throttle guarantees a push never lands on a full buffer.
  always_ff @(posedge clk) begin
    if (rstn && !i_flush) begin
      assert (!(i_push && !i_pop && (r_count == c_full)));
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Instruction fetch front end. Issues reads to a one-cycle
//                synchronous instruction RAM, buffers responses in a 3-entry
//                FIFO and presents them to the decoder with valid/ready.
//                Redirect flushes the buffer and restarts at a new address.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = c_reset_pc,
  parameter int          IMEM_ADDR_W = 12
) (
  input  logic                   clk,
  input  logic                   rstn,
  output logic                   imem_en,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]            imem_rdata,
  output logic [31:0]            instr_raw,
  output logic [31:0]            instr_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc
);

  fetch_state_t r_state;
  logic [31:0]  r_fetch_pc;
  logic [31:0]  r_inflight_pc;
  logic         r_inflight;
  logic         r_stale;

  logic [1:0]   w_count;
  logic [2:0]   w_outstanding;
  logic         w_run;
  logic         w_redirect;
  logic         w_issue;
  logic         w_push;
  logic         w_pop;
  logic [31:0]  w_redirect_pc;
  fetch_entry_t w_head;
  fetch_entry_t w_push_entry;

  // Everything is quiet while reset is held, even before the edge lands.
  assign w_run         = rstn && (r_state == ST_RUN);
  assign w_redirect    = w_run && redirect;
  assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;

  // Buffered plus outstanding reads may never exceed the buffer depth.
  assign w_outstanding = {1'b0, w_count} + {2'b00, r_inflight};
  assign w_issue       = w_run && !redirect && (w_outstanding < 3'(c_fifo_depth));

  // A response arriving in a redirect cycle, or marked stale, is dropped.
  assign w_push        = r_inflight && !r_stale && !w_redirect;
  assign w_pop         = instr_valid && instr_ready;

  assign w_push_entry.pc    = r_inflight_pc;
  assign w_push_entry.instr = imem_rdata;

  assign imem_en     = w_issue;
  assign imem_addr   = r_fetch_pc[IMEM_ADDR_W+1:2];
  assign instr_valid = w_run && (w_count != 2'd0);
  assign instr_raw   = instr_valid ? w_head.instr : c_nop_instr;
  assign instr_pc    = instr_valid ? w_head.pc    : RESET_PC;

  fetch_fifo u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_redirect),
    .i_data  (w_push_entry),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // FSM, fetch PC and in-flight tracking for the single outstanding read.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state       <= ST_BOOT;
      r_fetch_pc    <= RESET_PC;
      r_inflight_pc <= RESET_PC;
      r_inflight    <= 1'b0;
      r_stale       <= 1'b0;
    end else begin
      r_state    <= ST_RUN;
      // RAM latency is one cycle, so the response always follows the issue.
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_fetch_pc;
      end
      // Stale stays set after a redirect until a fresh read is issued.
      if (w_issue) begin
        r_stale <= 1'b0;
      end else if (w_redirect) begin
        r_stale <= 1'b1;
      end
      // Redirect overrides sequential advance; +4 wraps naturally at 2^32.
      if (w_redirect) begin
        r_fetch_pc <= w_redirect_pc;
      end else if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Directed bench for instr_fetch with a behavioural one-cycle
//                instruction RAM holding RAM[w] = 32'h1000_0000 + w.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  localparam int          AW  = 12;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk;
  logic          rstn;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic [31:0]   instr_raw;
  logic [31:0]   instr_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic          redirect;
  logic [31:0]   redirect_pc;

  int n_vec;
  int n_err;

  instr_fetch #(
    .RESET_PC    (32'h0000_0000),
    .IMEM_ADDR_W (AW)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instr_raw   (instr_raw),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction RAM with contents derived from the word address.
  always @(posedge clk) begin
    if (imem_en) begin
      imem_rdata <= 32'h1000_0000 + {20'd0, imem_addr};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then settle.
  task automatic cyc(input logic rn, input logic rdy, input logic rd, input logic [31:0] rpc);
    @(negedge clk);
    rstn        = rn;
    instr_ready = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    #1;
  endtask

  // Expect a live instruction at the given byte address.
  task automatic expect_instr(input string tag, input logic [31:0] pc, input logic [31:0] word);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, "_pc"},    instr_pc,  pc);
    chk({tag, "_raw"},   instr_raw, word);
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    rstn        = 1'b0;
    instr_ready = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    imem_rdata  = 32'd0;

    // ---- reset state -------------------------------------------------------
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_raw",   instr_raw, NOP);
    chk("rst_pc",    instr_pc,  32'd0);
    chk("rst_en",    {31'd0, imem_en}, 32'd0);

    // ---- release: boot cycle, then RUN cycles 0 and 1 ----------------------
    cyc(1, 1, 0, 0);
    chk("boot_en", {31'd0, imem_en}, 32'd0);
    cyc(1, 1, 0, 0);
    chk("c0_en",    {31'd0, imem_en}, 32'd1);
    chk("c0_addr",  {20'd0, imem_addr}, 32'd0);
    chk("c0_valid", {31'd0, instr_valid}, 32'd0);
    cyc(1, 1, 0, 0);
    chk("c1_valid", {31'd0, instr_valid}, 32'd0);
    chk("c1_addr",  {20'd0, imem_addr}, 32'd1);

    // ---- streaming, one instruction per cycle from cycle 2 -----------------
    for (int k = 0; k < 6; k++) begin
      cyc(1, 1, 0, 0);
      expect_instr("stream", 32'(4 * k), 32'h1000_0000 + 32'(k));
    end

    // ---- one-cycle reset mid-stream ----------------------------------------
    cyc(0, 1, 0, 0);
    chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
    chk("midrst_raw",   instr_raw, NOP);
    cyc(1, 1, 0, 0);
    chk("postrst_valid", {31'd0, instr_valid}, 32'd0);
    chk("postrst_raw",   instr_raw, NOP);
    chk("postrst_en",    {31'd0, imem_en}, 32'd0);
    cyc(1, 1, 0, 0);
    chk("restart_en",   {31'd0, imem_en}, 32'd1);
    chk("restart_addr", {20'd0, imem_addr}, 32'd0);
    cyc(1, 1, 0, 0);

    // ---- backpressure: ready low for 5 cycles from first valid -------------
    cyc(1, 0, 0, 0);
    expect_instr("stall2", 32'h0, 32'h1000_0000);
    chk("stall2_en", {31'd0, imem_en}, 32'd1);
    for (int k = 3; k < 7; k++) begin
      cyc(1, 0, 0, 0);
      expect_instr("stall_hold", 32'h0, 32'h1000_0000);
      chk("stall_en", {31'd0, imem_en}, 32'd0);
    end
    cyc(1, 1, 0, 0);
    expect_instr("resume0", 32'h0, 32'h1000_0000);
    chk("resume0_en", {31'd0, imem_en}, 32'd0);
    cyc(1, 1, 0, 0);
    expect_instr("resume4", 32'h4, 32'h1000_0001);
    chk("resume4_en", {31'd0, imem_en}, 32'd1);
    cyc(1, 1, 0, 0);
    expect_instr("resume8", 32'h8, 32'h1000_0002);
    cyc(1, 1, 0, 0);
    expect_instr("resume12", 32'hC, 32'h1000_0003);
    cyc(1, 1, 0, 0);
    expect_instr("resume16", 32'h10, 32'h1000_0004);

    // ---- fill the FIFO, then redirect to an unaligned address --------------
    cyc(1, 0, 0, 0);
    expect_instr("fill20a", 32'h14, 32'h1000_0005);
    cyc(1, 0, 0, 0);
    expect_instr("fill20b", 32'h14, 32'h1000_0005);
    cyc(1, 0, 0, 0);
    expect_instr("full20", 32'h14, 32'h1000_0005);
    chk("full_en", {31'd0, imem_en}, 32'd0);
    cyc(1, 0, 1, 32'h0000_0103);
    chk("redir_en", {31'd0, imem_en}, 32'd0);
    cyc(1, 1, 0, 0);
    chk("redir1_valid", {31'd0, instr_valid}, 32'd0);
    chk("redir1_en",    {31'd0, imem_en}, 32'd1);
    chk("redir1_addr",  {20'd0, imem_addr}, 32'h40);
    cyc(1, 1, 0, 0);
    chk("redir2_valid", {31'd0, instr_valid}, 32'd0);
    cyc(1, 1, 0, 0);
    expect_instr("redir3", 32'h100, 32'h1000_0040);
    cyc(1, 1, 0, 0);
    expect_instr("redir4", 32'h104, 32'h1000_0041);

    // ---- back-to-back redirects; handshake in the first redirect cycle -----
    cyc(1, 1, 1, 32'h0000_0200);
    expect_instr("dbl0", 32'h108, 32'h1000_0042);
    cyc(1, 1, 1, 32'h0000_0300);
    chk("dbl1_valid", {31'd0, instr_valid}, 32'd0);
    chk("dbl1_en",    {31'd0, imem_en}, 32'd0);
    cyc(1, 1, 0, 0);
    chk("dbl2_valid", {31'd0, instr_valid}, 32'd0);
    chk("dbl2_addr",  {20'd0, imem_addr}, 32'hC0);
    cyc(1, 1, 0, 0);
    chk("dbl3_valid", {31'd0, instr_valid}, 32'd0);
    cyc(1, 1, 0, 0);
    expect_instr("dbl4", 32'h300, 32'h1000_00C0);
    cyc(1, 1, 0, 0);
    expect_instr("dbl5", 32'h304, 32'h1000_00C1);

    // ---- redirect near the top of the address space: PC wrap ---------------
    cyc(1, 1, 1, 32'hFFFF_FFF8);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    chk("wrap2_valid", {31'd0, instr_valid}, 32'd0);
    cyc(1, 1, 0, 0);
    expect_instr("wrapF8", 32'hFFFF_FFF8, 32'h1000_0FFE);
    cyc(1, 1, 0, 0);
    expect_instr("wrapFC", 32'hFFFF_FFFC, 32'h1000_0FFF);
    cyc(1, 1, 0, 0);
    expect_instr("wrap00", 32'h0000_0000, 32'h1000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, byte address of the first fetch.
REQ-002 The module SHALL have parameter IMEM_ADDR_W, default 12, word-address width of instruction memory.
REQ-003 The module SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 The module SHALL have port rstn, input, 1, reset, synchronous and active-low.
REQ-005 The module SHALL have port imem_en, output, 1, read strobe to synchronous instruction RAM.
REQ-006 The module SHALL have port imem_addr, output, IMEM_ADDR_W, word address equal to fetch_pc[IMEM_ADDR_W+1:2].
REQ-007 The module SHALL have port imem_rdata, input, 32, read data, valid exactly one cycle after imem_en.
REQ-008 The module SHALL have port instr_raw, output, 32, instruction word presented to the decoder.
REQ-009 The module SHALL have port instr_pc, output, 32, byte address of instr_raw.
REQ-010 The module SHALL have port instr_valid, output, 1, instr_raw/instr_pc hold a live instruction.
REQ-011 The module SHALL have port instr_ready, input, 1, decoder accepts; transfer when valid && ready.
REQ-012 The module SHALL have port redirect, input, 1, flush and restart at redirect_pc.
REQ-013 The module SHALL have port redirect_pc, input, 32, new fetch byte address; bits [1:0] are ignored and treated as 0.

Function
REQ-014 The module SHALL implement FSM states BOOT and RUN: BOOT while rstn low; BOOT->RUN on the first edge with rstn high; RUN->BOOT only on reset.
REQ-015 The module SHALL hold fetch_pc, an internal register, and SHALL advance it by 4 on every issued read, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-016 The module SHALL buffer responses in a 3-entry FIFO of {pc, instr}; the head drives instr_pc/instr_raw, and instr_valid = (count != 0).
REQ-017 In RUN, the module SHALL issue a read (imem_en=1) when registered count + inflight < 3 and redirect=0; inflight is a 1-bit register set on issue and cleared on response.
REQ-018 The module SHALL push the response into the FIFO in the cycle after issue unless the response is stale (REQ-021).
REQ-019 With instr_ready held high, the module SHALL sustain one transfer per cycle, and the first instr_valid SHALL occur 2 cycles after the first RUN cycle (issue in cycle 0, data in cycle 1, valid in cycle 2).
REQ-020 When instr_ready=0, the module SHALL hold instr_raw/instr_pc stable, SHALL never drop or duplicate an instruction, and SHALL stall issue when count+inflight=3.
REQ-021 On redirect=1 the module SHALL, at the next edge, empty the FIFO, mark any in-flight response stale (discarded on arrival), load fetch_pc <= {redirect_pc[31:2],2'b00}, and issue no read in the redirect cycle.
REQ-022 A handshake completing in a redirect cycle SHALL count as a transfer; the module SHALL NOT re-present that instruction.
REQ-023 The first instruction after a redirect in cycle r SHALL have instr_valid in cycle r+3 at the earliest.
REQ-024 For redirects in consecutive cycles, the last redirect_pc SHALL win.
REQ-025 For a simultaneous push and pop, the module SHALL keep count unchanged; for a push to a full FIFO, the module SHALL never occur by construction, and an assertion SHALL check this.

Reset
REQ-026 While rstn=0 at an edge, the module SHALL set state=BOOT, fetch_pc=RESET_PC, count=0, inflight=0, stale=0.
REQ-027 During reset and in BOOT, the module SHALL drive imem_en=0, instr_valid=0, instr_raw=32'h0000_0013 (NOP), and instr_pc=RESET_PC.
REQ-028 On reset asserted mid-operation, the module SHALL discard all buffered and in-flight data, and SHALL ignore redirect during reset.

Structure
REQ-029 Package fetch_pkg SHALL hold RESET_PC default, the NOP constant 32'h0000_0013, the FIFO depth 3, and the fetch_entry_t struct {pc[31:0], instr[31:0]}.
REQ-030 FIFO storage SHALL be a sub-module fetch_fifo (3 x fetch_entry_t, push/pop/flush, count output); all control SHALL live in instr_fetch.

Verification
REQ-031 Reset release, RAM[w]=32'h1000_0000+w, ready=1 -> valid from cycle 2, pcs 0,4,8,... one per cycle with matching words.
REQ-032 ready=0 for 5 cycles after the first valid -> pc=0 held, imem_en stops after 3 outstanding, then on resume pcs 0,4,8,12 are delivered with no gaps or repeats.
REQ-033 redirect=1 with redirect_pc=32'h0000_0103 while FIFO is full -> next delivered pc=32'h0000_0100 at r+3, and no stale words appear.
REQ-034 Redirect on cycles r and r+1 (pc 0x200 then 0x300) -> first delivered pc=0x300.
REQ-035 redirect_pc=32'hFFFF_FFF8 -> pcs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 in order.
REQ-036 rstn pulled low for 1 cycle mid-stream with valid=1 -> the next cycle has valid=0 and instr_raw=NOP, and the stream restarts at RESET_PC.
